// File: rtl/gate_tt_sequencer.sv
// Exhaustive truth-table sequencer for one attached combinational gate.
// Steps drv through every input vector, holds each for a settle window,
// samples y_in once per vector against EXP_TT and reports pass/fail,
// the mismatch count and the first failing vector.
module gate_tt_sequencer #(
    parameter int                     N_IN          = 2,
    parameter int                     SETTLE_CYCLES = 2,
    parameter logic [(2**N_IN)-1:0]   EXP_TT        = 4'b0111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   drv,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
);

    // Settle counter only needs to reach SETTLE_CYCLES-1; keep it at least 1 bit wide.
    localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]   VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]     ERR_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_IN-1:0]    r_drv;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [N_IN:0]      r_err_count;
    logic               r_fail_valid;
    logic [N_IN-1:0]    r_fail_vec;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [N_IN-1:0]    w_drv_next;
    logic               w_busy_next;
    logic               w_done_next;
    logic               w_pass_next;
    logic [N_IN:0]      w_err_count_next;
    logic               w_fail_valid_next;
    logic [N_IN-1:0]    w_fail_vec_next;
    logic               w_mismatch;

    // Case inequality so an undriven or X gate output is reported as a mismatch.
    assign w_mismatch = (y_in !== EXP_TT[r_drv]);

    // State and result registers; reset aborts any run without producing done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_drv        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_drv        <= w_drv_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_pass       <= w_pass_next;
            r_err_count  <= w_err_count_next;
            r_fail_valid <= w_fail_valid_next;
            r_fail_vec   <= w_fail_vec_next;
        end
    end

    // Next-state and output logic: settle each vector, sample once, advance or finish.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_drv_next        = r_drv;
        w_busy_next       = r_busy;
        w_done_next       = 1'b0;
        w_pass_next       = r_pass;
        w_err_count_next  = r_err_count;
        w_fail_valid_next = r_fail_valid;
        w_fail_vec_next   = r_fail_vec;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_next       = 1'b1;
                    w_drv_next        = '0;
                    w_cnt_next        = '0;
                    w_err_count_next  = '0;
                    w_fail_valid_next = 1'b0;
                    w_fail_vec_next   = '0;
                    w_pass_next       = 1'b0;
                    w_state_next      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    w_err_count_next = r_err_count + ERR_ONE;
                    if (!r_fail_valid) begin
                        w_fail_valid_next = 1'b1;
                        w_fail_vec_next   = r_drv;
                    end
                end
                if (r_drv != VEC_LAST) begin
                    w_drv_next   = r_drv + 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_SETTLE;
                end else begin
                    // Last vector: drv holds here until the next start.
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_pass_next  = !r_fail_valid && !w_mismatch;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign drv        = r_drv;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: a default nand2 checker (A) and an inverter
// checker with N_IN=1, SETTLE_CYCLES=1 (B). The attached "gate" is a truth
// table chosen per scenario; expected timing and results come from a
// per-run model (vector index from elapsed cycles, mismatch count from
// comparing the attached table against the expected table).
module tb_gate_tt_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;

    logic [1:0]  drv_a;
    logic        y_a, busy_a, done_a, pass_a, fv_a;
    logic [2:0]  err_a;
    logic [1:0]  fvec_a;
    logic [3:0]  tt_a;

    logic [0:0]  drv_b;
    logic        y_b, busy_b, done_b, pass_b, fv_b;
    logic [1:0]  err_b;
    logic [0:0]  fvec_b;
    logic [1:0]  tt_b;

    int checks   = 0;
    int failures = 0;

    // The attached gates are pure truth tables indexed by the drive vector.
    assign y_a = tt_a[drv_a];
    assign y_b = tt_b[drv_b];

    gate_tt_sequencer dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .drv        (drv_a),
        .y_in       (y_a),
        .busy       (busy_a),
        .done       (done_a),
        .pass       (pass_a),
        .err_count  (err_a),
        .fail_valid (fv_a),
        .fail_vec   (fvec_a)
    );

    gate_tt_sequencer #(
        .N_IN          (1),
        .SETTLE_CYCLES (1),
        .EXP_TT        (2'b01)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .drv        (drv_b),
        .y_in       (y_b),
        .busy       (busy_b),
        .done       (done_b),
        .pass       (pass_b),
        .err_count  (err_b),
        .fail_valid (fv_b),
        .fail_vec   (fvec_b)
    );

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        tt_a = 4'b0111; tt_b = 2'b01;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({drv_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a} !== 11'd0) begin
            failures++;
            $display("FAIL reset_a got %b exp 0", {drv_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a});
        end
        checks++;
        if ({drv_b, busy_b, done_b, pass_b, err_b, fv_b, fvec_b} !== 7'd0) begin
            failures++;
            $display("FAIL reset_b got %b exp 0", {drv_b, busy_b, done_b, pass_b, err_b, fv_b, fvec_b});
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    // One or more runs on DUT A or B with attached table tt; every cycle is checked
    // against the elapsed-cycle model. nruns>1 holds start high (back-to-back);
    // extra_j>0 pulses start again at edge k+extra_j while busy.
    task automatic test_run(input bit use_b, input logic [3:0] tt, input int nruns,
                            input int extra_j, input string name);
        int nv, s, t_run, period, exp_err, exp_first, r, exp_drv;
        bit exp_busy, exp_done, exp_fv, exp_pass;
        logic [3:0] exptt;
        int o_drv, o_err, o_fvec;
        bit o_busy, o_done, o_pass, o_fv;
        nv    = use_b ? 2 : 4;
        s     = use_b ? 1 : 2;
        exptt = use_b ? 4'b0001 : 4'b0111;
        if (use_b) tt_b = tt[1:0]; else tt_a = tt;
        exp_err = 0; exp_first = 0;
        for (int v = nv - 1; v >= 0; v--) begin
            if (tt[v] != exptt[v]) begin
                exp_err++;
                exp_first = v;
            end
        end
        exp_fv   = (exp_err != 0);
        exp_pass = (exp_err == 0);
        t_run    = nv * (s + 1);
        period   = t_run + 1;

        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        for (int j = 0; j < nruns * period; j++) begin
            @(negedge clk);
            // state after edge k+j; choose start for edge k+j+1
            if (((j + 1) <= (nruns - 1) * period) || ((j + 1) == extra_j)) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                if (use_b) start_b = 1'b0; else start_a = 1'b0;
            end
            o_drv  = use_b ? int'(drv_b)  : int'(drv_a);
            o_busy = use_b ? busy_b : busy_a;
            o_done = use_b ? done_b : done_a;
            o_pass = use_b ? pass_b : pass_a;
            o_fv   = use_b ? fv_b   : fv_a;
            o_err  = use_b ? int'(err_b)  : int'(err_a);
            o_fvec = use_b ? int'(fvec_b) : int'(fvec_a);
            r        = j % period;
            exp_drv  = (r < t_run) ? r / (s + 1) : nv - 1;
            exp_busy = (r < t_run);
            exp_done = (r == t_run);
            checks++;
            if (o_drv !== exp_drv || o_busy !== exp_busy || o_done !== exp_done) begin
                failures++;
                $display("FAIL %s timing j=%0d drv/busy/done got %0d/%0b/%0b exp %0d/%0b/%0b",
                         name, j, o_drv, o_busy, o_done, exp_drv, exp_busy, exp_done);
            end
            if (r == 0) begin
                checks++;
                if (o_err !== 0 || o_fv !== 1'b0 || o_pass !== 1'b0) begin
                    failures++;
                    $display("FAIL %s start_clear j=%0d err/fv/pass got %0d/%0b/%0b exp 0/0/0",
                             name, j, o_err, o_fv, o_pass);
                end
            end
            if (exp_done) begin
                checks++;
                if (o_err !== exp_err || o_fv !== exp_fv || o_pass !== exp_pass ||
                    (exp_fv && o_fvec !== exp_first)) begin
                    failures++;
                    $display("FAIL %s result j=%0d err/fv/fvec/pass got %0d/%0b/%0d/%0b exp %0d/%0b/%0d/%0b",
                             name, j, o_err, o_fv, o_fvec, o_pass, exp_err, exp_fv, exp_first, exp_pass);
                end
                $display("%s run done at k+%0d err=%0d fail_vec=%0d pass=%0b", name, j, o_err, o_fvec, o_pass);
            end
        end
        // done lasts one cycle; results and drv hold while idle
        @(negedge clk);
        o_drv  = use_b ? int'(drv_b) : int'(drv_a);
        o_done = use_b ? done_b : done_a;
        o_busy = use_b ? busy_b : busy_a;
        o_pass = use_b ? pass_b : pass_a;
        o_err  = use_b ? int'(err_b) : int'(err_a);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_drv !== nv - 1 ||
            o_pass !== exp_pass || o_err !== exp_err) begin
            failures++;
            $display("FAIL %s idle_hold done/busy/drv/pass/err got %0b/%0b/%0d/%0b/%0d exp 0/0/%0d/%0b/%0d",
                     name, o_done, o_busy, o_drv, o_pass, o_err, nv - 1, exp_pass, exp_err);
        end
    endtask

    // Abort a run with and2 attached while drv=2; no done may follow, then nand2 passes.
    task automatic test_reset_midrun();
        bit saw_done;
        tt_a = 4'b1000;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        // after edge k+6: vectors 0 and 1 sampled, both mismatch for and2
        checks++;
        if (drv_a !== 2'd2 || err_a !== 3'd2 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre drv/err/busy got %0d/%0d/%0b exp 2/2/1", drv_a, err_a, busy_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (drv_a !== 2'd0 || busy_a !== 1'b0 || err_a !== 3'd0 || done_a !== 1'b0 || fv_a !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset drv/busy/err/done/fv got %0d/%0b/%0d/%0b/%0b exp 0/0/0/0/0",
                     drv_a, busy_a, err_a, done_a, fv_a);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done_a || busy_a) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done got activity=%0b exp 0", saw_done);
        end
        $display("test_reset_midrun aborted run, no done observed=%0b", !saw_done);
        test_run(1'b0, 4'b0111, 1, 0, "after_reset_nand2");
    endtask

    task automatic test_random();
        logic [3:0] tt;
        for (int i = 0; i < 6; i++) begin
            tt = 4'($urandom);
            test_run(1'b0, tt, 1, 0, "random_a");
        end
        for (int i = 0; i < 3; i++) begin
            tt = 4'($urandom_range(0, 3));
            test_run(1'b1, tt, 1, 0, "random_b");
        end
    endtask

    initial begin
        test_reset();
        test_run(1'b0, 4'b0111, 1, 0, "nand2");
        test_run(1'b0, 4'b1000, 1, 0, "and2");
        test_run(1'b0, 4'b1111, 1, 0, "tied1");
        test_run(1'b0, 4'b0111, 1, 5, "busy_start");
        test_run(1'b0, 4'b0111, 3, 0, "back_to_back");
        test_run(1'b0, 4'b0110, 2, 0, "back_to_back_xor");
        test_reset_midrun();
        test_run(1'b1, 4'b0001, 1, 0, "inverter");
        test_run(1'b1, 4'b0000, 1, 0, "inverter_stuck0");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
